pc_npc_unit: RTL and testbench

- Parametrised successor to the single program-counter register: holds the PC/nPC pair for the fetch stage.
- Supports a delayed branch: the slot instruction at nPC executes before the target.
- Supports a non-delayed trap redirect.
- Any redirect that arrives during a stall is buffered in a one-entry pending register and applied on the next advance. A saturating advance counter feeds performance monitoring.

---
 rtl/pc_npc_unit_pkg.sv | 23 ++
 rtl/pc_npc_unit_redirect_buf.sv | 86 ++++++++
 rtl/pc_npc_unit.sv | 96 +++++++++
 tb/tb_pc_npc_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_npc_unit_pkg.sv
// Shared definitions for the PC/nPC fetch unit: pending-redirect states,
// default geometry and the redirect priority select codes.
package pc_pkg;

    localparam int PC_WIDTH = 32;
    localparam int PC_INC   = 4;

    typedef enum logic [1:0] {
        PEND_EMPTY = 2'd0,
        PEND_BR    = 2'd1,
        PEND_TRAP  = 2'd2
    } pend_state_t;

    // Redirect chosen on an advance edge; listed highest priority first after SEQ
    typedef enum logic [2:0] {
        SEL_SEQ       = 3'd0,
        SEL_NEW_TRAP  = 3'd1,
        SEL_PEND_TRAP = 3'd2,
        SEL_NEW_BR    = 3'd3,
        SEL_PEND_BR   = 3'd4
    } redir_sel_t;

endpackage

// File: rtl/pc_npc_unit_redirect_buf.sv
// One-entry pending redirect buffer plus the priority select that decides
// which redirect (new or buffered) the PC/nPC registers apply on an advance.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_le_pc,
    input  logic             i_branch_valid,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_trap_valid,
    input  logic [WIDTH-1:0] i_trap_vector,
    output redir_sel_t       o_sel,
    output logic [WIDTH-1:0] o_addr,
    output logic             o_pend_valid,
    output logic             o_pend_is_trap
);

    pend_state_t      r_state;
    logic [WIDTH-1:0] r_addr;
    logic             r_pend_valid;
    logic             r_pend_is_trap;
    redir_sel_t       w_sel;
    logic [WIDTH-1:0] w_addr;

    // Pending state and address: cleared by any advance, loaded on stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= PEND_EMPTY;
            r_addr         <= {WIDTH{1'b0}};
            r_pend_valid   <= 1'b0;
            r_pend_is_trap <= 1'b0;
        end else if (i_le_pc) begin
            r_state        <= PEND_EMPTY;
            r_addr         <= {WIDTH{1'b0}};
            r_pend_valid   <= 1'b0;
            r_pend_is_trap <= 1'b0;
        end else if (i_trap_valid) begin
            r_state        <= PEND_TRAP;
            r_addr         <= i_trap_vector;
            r_pend_valid   <= 1'b1;
            r_pend_is_trap <= 1'b1;
        end else if (i_branch_valid && (r_state != PEND_TRAP)) begin
            // A buffered trap outranks any later branch in the same stall
            r_state        <= PEND_BR;
            r_addr         <= i_branch_target;
            r_pend_valid   <= 1'b1;
            r_pend_is_trap <= 1'b0;
        end else begin
            r_state        <= r_state;
            r_addr         <= r_addr;
            r_pend_valid   <= r_pend_valid;
            r_pend_is_trap <= r_pend_is_trap;
        end
    end

    // Priority select: new trap, pending trap, new branch, pending branch
    always_comb begin
        w_sel  = SEL_SEQ;
        w_addr = {WIDTH{1'b0}};
        if (i_trap_valid) begin
            w_sel  = SEL_NEW_TRAP;
            w_addr = i_trap_vector;
        end else if (r_state == PEND_TRAP) begin
            w_sel  = SEL_PEND_TRAP;
            w_addr = r_addr;
        end else if (i_branch_valid) begin
            w_sel  = SEL_NEW_BR;
            w_addr = i_branch_target;
        end else if (r_state == PEND_BR) begin
            w_sel  = SEL_PEND_BR;
            w_addr = r_addr;
        end else begin
            w_sel  = SEL_SEQ;
            w_addr = {WIDTH{1'b0}};
        end
    end

    assign o_sel          = w_sel;
    assign o_addr         = w_addr;
    assign o_pend_valid   = r_pend_valid;
    assign o_pend_is_trap = r_pend_is_trap;

endmodule

// File: rtl/pc_npc_unit.sv
// PC/nPC pair for the fetch stage with delayed branches, non-delayed trap
// redirects, stall-time redirect buffering and a saturating advance counter.
module pc_npc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int               INC      = PC_INC,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             le_pc,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_vector,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic             pend_valid,
    output logic             pend_is_trap,
    output logic [CNT_W-1:0] adv_count
);

    localparam logic [WIDTH-1:0] L_INC     = WIDTH'(INC);
    localparam logic [CNT_W-1:0] L_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_npc;
    logic [CNT_W-1:0] r_cnt;
    redir_sel_t       w_sel;
    logic [WIDTH-1:0] w_addr;

    pc_redirect_buf #(
        .WIDTH(WIDTH)
    ) u_redirect_buf (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_le_pc        (le_pc),
        .i_branch_valid (branch_valid),
        .i_branch_target(branch_target),
        .i_trap_valid   (trap_valid),
        .i_trap_vector  (trap_vector),
        .o_sel          (w_sel),
        .o_addr         (w_addr),
        .o_pend_valid   (pend_valid),
        .o_pend_is_trap (pend_is_trap)
    );

    // PC/nPC update: traps jump immediately, branches keep the delay slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + L_INC;
        end else if (le_pc) begin
            case (w_sel)
                SEL_NEW_TRAP, SEL_PEND_TRAP: begin
                    r_pc  <= w_addr;
                    r_npc <= w_addr + L_INC;
                end
                SEL_NEW_BR, SEL_PEND_BR: begin
                    r_pc  <= r_npc;
                    r_npc <= w_addr;
                end
                SEL_SEQ: begin
                    r_pc  <= r_npc;
                    r_npc <= r_npc + L_INC;
                end
                default: begin
                    r_pc  <= r_npc;
                    r_npc <= r_npc + L_INC;
                end
            endcase
        end else begin
            r_pc  <= r_pc;
            r_npc <= r_npc;
        end
    end

    // Saturating advance counter for performance monitoring
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (le_pc && (r_cnt != L_CNT_MAX)) begin
            r_cnt <= r_cnt + L_CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign pc_out    = r_pc;
    assign npc_out   = r_npc;
    assign adv_count = r_cnt;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Randomised and directed bench for pc_npc_unit against a behavioural model
// of the PC/nPC redirect rules; a CNT_W=2 copy exercises counter saturation.
module tb_pc_npc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        le_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        trap_valid;
    logic [31:0] trap_vector;

    logic [31:0] pc_out, npc_out, pc_s, npc_s;
    logic        pend_valid, pend_is_trap, pv_s, pt_s;
    logic [15:0] adv_count;
    logic [1:0]  adv_s;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending kind 0=none 1=branch 2=trap
    logic [31:0] m_pc, m_npc, m_pa;
    int          m_pk;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_npc_unit #(.WIDTH(32), .RESET_PC(32'h0), .INC(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .le_pc(le_pc),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .pc_out(pc_out), .npc_out(npc_out), .pend_valid(pend_valid),
        .pend_is_trap(pend_is_trap), .adv_count(adv_count)
    );

    pc_npc_unit #(.WIDTH(32), .RESET_PC(32'h0), .INC(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .le_pc(le_pc),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .pc_out(pc_s), .npc_out(npc_s), .pend_valid(pv_s),
        .pend_is_trap(pt_s), .adv_count(adv_s)
    );

    task automatic model_reset();
        m_pc  = 32'h0;
        m_npc = 32'h4;
        m_pa  = 32'h0;
        m_pk  = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic le, input logic bv, input logic [31:0] bt,
                              input logic tv, input logic [31:0] tvec);
        logic [31:0] old_npc;
        old_npc = m_npc;
        if (le) begin
            if (tv) begin
                m_pc = tvec; m_npc = tvec + 32'd4;
            end else if (m_pk == 2) begin
                m_pc = m_pa; m_npc = m_pa + 32'd4;
            end else if (bv) begin
                m_pc = old_npc; m_npc = bt;
            end else if (m_pk == 1) begin
                m_pc = old_npc; m_npc = m_pa;
            end else begin
                m_pc = old_npc; m_npc = old_npc + 32'd4;
            end
            m_pk  = 0;
            m_cnt = m_cnt + 1;
        end else begin
            if (tv) begin
                m_pk = 2; m_pa = tvec;
            end else if (bv && m_pk != 2) begin
                m_pk = 1; m_pa = bt;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("pc", pc_out, m_pc);
        cmp("npc", npc_out, m_npc);
        cmp("pend_valid", {31'd0, pend_valid}, (m_pk != 0) ? 32'd1 : 32'd0);
        if (m_pk != 0) cmp("pend_is_trap", {31'd0, pend_is_trap}, (m_pk == 2) ? 32'd1 : 32'd0);
        cmp("adv_count", {16'd0, adv_count}, (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        cmp("pc_sat", pc_s, m_pc);
        cmp("adv_sat", {30'd0, adv_s}, (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    endtask

    // One clock: drive at negedge, model updates at posedge, compare at next negedge
    task automatic cycle(input logic le, input logic bv, input logic [31:0] bt,
                         input logic tv, input logic [31:0] tvec);
        le_pc = le; branch_valid = bv; branch_target = bt;
        trap_valid = tv; trap_vector = tvec;
        @(posedge clk);
        model_step(le, bv, bt, tv, tvec);
        @(negedge clk);
        check_all();
        branch_valid = 1'b0; trap_valid = 1'b0;
    endtask

    // Asynchronous reset pulse mid-cycle, checked before any clock edge
    task automatic async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        cmp("rst_pc", pc_out, 32'h0);
        cmp("rst_pend", {31'd0, pend_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; le_pc = 1'b0; branch_valid = 1'b0; trap_valid = 1'b0;
        branch_target = 32'h0; trap_vector = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        cmp("t1_rst_pc", pc_out, 32'h0);
        cmp("t1_rst_npc", npc_out, 32'h4);
        reset_n = 1'b1;

        // 1: sequential advances
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  cmp("t1_pc1", pc_out, 32'h4);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  cmp("t1_pc2", pc_out, 32'h8);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  cmp("t1_pc3", pc_out, 32'hC);
        cmp("t1_npc", npc_out, 32'h10);
        cmp("t1_cnt", {16'd0, adv_count}, 32'd3);

        // 2: delayed branch
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
        cmp("t2_pc0", pc_out, 32'h100);
        cycle(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        cmp("t2_pc1", pc_out, 32'h104);  cmp("t2_npc1", npc_out, 32'h200);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t2_pc2", pc_out, 32'h200);  cmp("t2_npc2", npc_out, 32'h204);

        // 3: two branches during one stall, newest wins
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
        cmp("t3_pv", {31'd0, pend_valid}, 32'd1);
        cmp("t3_pt", {31'd0, pend_is_trap}, 32'd0);
        cmp("t3_pc_hold", pc_out, 32'h200);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t3_pc", pc_out, 32'h204);  cmp("t3_npc", npc_out, 32'h400);
        cmp("t3_pv0", {31'd0, pend_valid}, 32'd0);

        // 4: pending trap blocks a later branch
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        cmp("t4_pt", {31'd0, pend_is_trap}, 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t4_pc", pc_out, 32'h80);  cmp("t4_npc", npc_out, 32'h84);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t4_npc2", npc_out, 32'h88);

        // 5: trap beats branch in the same cycle
        cycle(1'b1, 1'b1, 32'h900, 1'b1, 32'h40);
        cmp("t5_pc", pc_out, 32'h40);  cmp("t5_npc", npc_out, 32'h44);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic le, bv, tv;
            le = ($urandom_range(0, 9) < 7);
            bv = ($urandom_range(0, 4) == 0);
            tv = ($urandom_range(0, 9) == 0);
            cycle(le, bv, $urandom, tv, ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : $urandom);
        end

        // 6: wrap, saturation, async reset with pending redirect
        async_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFFFFF8);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t6_pc", pc_out, 32'hFFFFFFFC);  cmp("t6_npc", npc_out, 32'h0);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t6_sat", {30'd0, adv_s}, 32'd3);
        cmp("t6_cnt", {16'd0, adv_count}, 32'd5);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
        cmp("t6_pv", {31'd0, pend_valid}, 32'd1);
        async_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cmp("t6_post_pc", pc_out, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
